// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: double-buffered framebuffer swap controller with vsync-aligned swap and back-buffer clear
module fb_swap_ctrl #(
  parameter int ADDR_BITS   = 17,
  parameter int DATA_BITS   = 12,
  parameter int FB_WORDS    = 76800,
  parameter int CLEAR_EN    = 1,
  parameter int CLEAR_VALUE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 swap_req,
  output logic                 swap_ack,
  input  logic                 draw_valid,
  output logic                 draw_ready,
  input  logic [ADDR_BITS-1:0] draw_addr,
  input  logic [DATA_BITS-1:0] draw_data,
  output logic                 front_sel,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_waddr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic                 mem_wbuf,
  output logic                 wr_oob,
  output logic                 busy
);
  typedef enum logic [1:0] {DRAW, WAIT_VSYNC, SWAP, CLEAR} state_t;
  localparam int CW = FB_WORDS > 1 ? $clog2(FB_WORDS) : 1;
  localparam logic [ADDR_BITS:0] FB_LIM = (ADDR_BITS+1)'(FB_WORDS);
  localparam logic [CW-1:0] CLR_LAST = CW'(FB_WORDS - 1);
  localparam state_t POST_SWAP = CLEAR_EN != 0 ? CLEAR : DRAW;
  state_t state_q, state_d;
  logic [CW-1:0] clr_q, clr_d;
  logic front_q, front_d;
  logic fs_q, fs_d;
  logic we_q, we_d;
  logic oob_q, oob_d;
  logic wbuf_q, wbuf_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic fs_rise, in_bounds;
  assign fs_rise = frame_start & ~fs_q;
  assign in_bounds = {1'b0, draw_addr} < FB_LIM;
  // next state, write-port staging and handshake outputs; ready/ack are masked while in reset
  always_comb begin
    state_d = state_q;
    clr_d = clr_q;
    front_d = front_q;
    fs_d = frame_start;
    we_d = 1'b0;
    oob_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wbuf_d = wbuf_q;
    draw_ready = 1'b0;
    swap_ack = 1'b0;
    case (state_q)
      DRAW: begin
        draw_ready = rst_n;
        if (draw_valid) begin
          we_d = in_bounds;
          oob_d = ~in_bounds;
          waddr_d = draw_addr;
          wdata_d = draw_data;
          wbuf_d = ~front_q;
        end
        if (swap_req) state_d = fs_rise ? SWAP : WAIT_VSYNC;
      end
      WAIT_VSYNC: state_d = fs_rise ? SWAP : WAIT_VSYNC;
      SWAP: begin
        swap_ack = rst_n;
        front_d = ~front_q;
        clr_d = '0;
        state_d = POST_SWAP;
      end
      default: begin
        we_d = 1'b1;
        waddr_d = ADDR_BITS'(clr_q);
        wdata_d = DATA_BITS'(CLEAR_VALUE);
        wbuf_d = ~front_q;
        clr_d = clr_q == CLR_LAST ? '0 : clr_q + CW'(1);
        state_d = clr_q == CLR_LAST ? DRAW : CLEAR;
      end
    endcase
  end
  // state and registered write port; reset restarts the clear of buffer 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= POST_SWAP;
      clr_q <= '0;
      front_q <= 1'b0;
      fs_q <= 1'b1;
      we_q <= 1'b0;
      oob_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wbuf_q <= 1'b1;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      front_q <= front_d;
      fs_q <= fs_d;
      we_q <= we_d;
      oob_q <= oob_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wbuf_q <= wbuf_d;
    end
  end
  assign busy = ~draw_ready;
  assign front_sel = front_q;
  assign mem_we = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign mem_wbuf = wbuf_q;
  assign wr_oob = oob_q;
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb_fb_swap_ctrl: directed and randomized checks of fb_swap_ctrl against a behavioural model
module tb_fb_swap_ctrl;
  localparam int AB = 5;
  localparam int DB = 12;
  localparam int FBW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic swap_req = 1'b0;
  logic draw_valid = 1'b0;
  logic [AB-1:0] draw_addr = '0;
  logic [DB-1:0] draw_data = '0;
  logic swap_ack, draw_ready, front_sel, mem_we, mem_wbuf, wr_oob, busy;
  logic [AB-1:0] mem_waddr;
  logic [DB-1:0] mem_wdata;
  int n_assert = 0;
  int n_fail = 0;

  fb_swap_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .FB_WORDS(FBW), .CLEAR_EN(1), .CLEAR_VALUE(0)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .swap_req(swap_req), .swap_ack(swap_ack),
    .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_addr(draw_addr), .draw_data(draw_data),
    .front_sel(front_sel), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wbuf(mem_wbuf), .wr_oob(wr_oob), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a buffer swap is pending/occurring, a clear has some words left,
  // otherwise the drawer owns the back buffer. e_* are the write-port values expected
  // after the next edge.
  bit m_valid = 0;
  bit m_front, m_fsp, m_wait, m_swap, e_rst;
  int m_clear_left, m_caddr;
  bit e_we, e_oob, e_wbuf;
  int e_waddr, e_wdata;

  always @(negedge clk) begin
    bit in_clear, in_draw, fsr;
    in_clear = !m_swap && m_clear_left > 0;
    in_draw = !m_swap && !in_clear && !m_wait;
    if (m_valid) begin
      chk("draw_ready", draw_ready, rst_n && in_draw);
      chk("busy", busy, !(rst_n && in_draw));
      chk("swap_ack", swap_ack, rst_n && m_swap);
      chk("front_sel", front_sel, m_front);
      chk("mem_we", mem_we, e_we);
      chk("wr_oob", wr_oob, e_oob);
      if (e_we || e_rst) begin
        chk("mem_waddr", mem_waddr, e_waddr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_wbuf", mem_wbuf, e_wbuf);
      end
      if (mem_we === 1'b1) chk("wbuf_vs_front", mem_wbuf == front_sel, 0);
    end
    if (!rst_n) begin
      m_valid = 1; m_front = 0; m_fsp = 1; m_wait = 0; m_swap = 0;
      m_clear_left = FBW; m_caddr = 0;
      e_we = 0; e_oob = 0; e_waddr = 0; e_wdata = 0; e_wbuf = 1; e_rst = 1;
    end else if (m_valid) begin
      e_rst = 0; e_we = 0; e_oob = 0;
      fsr = frame_start && !m_fsp;
      if (m_swap) begin
        m_front = !m_front; m_swap = 0; m_clear_left = FBW; m_caddr = 0;
      end else if (in_clear) begin
        e_we = 1; e_waddr = m_caddr; e_wdata = 0; e_wbuf = !m_front;
        m_caddr++; m_clear_left--;
      end else if (m_wait) begin
        if (fsr) begin m_swap = 1; m_wait = 0; end
      end else begin
        if (draw_valid) begin
          if (int'(draw_addr) < FBW) begin
            e_we = 1; e_waddr = int'(draw_addr); e_wdata = int'(draw_data); e_wbuf = !m_front;
          end else e_oob = 1;
        end
        if (swap_req) begin
          if (fsr) m_swap = 1; else m_wait = 1;
        end
      end
      m_fsp = frame_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quick_swap();
    logic f0;
    f0 = front_sel;
    swap_req = 1; frame_start = 1; draw_valid = 1; draw_addr = 3; draw_data = 12'h123;
    tick();
    swap_req = 0; frame_start = 0; draw_valid = 0;
    chk("qs_ack", swap_ack, 1);
    chk("qs_we", mem_we, 1);
    chk("qs_addr", mem_waddr, 3);
    chk("qs_data", mem_wdata, 12'h123);
    chk("qs_wbuf", mem_wbuf, !f0);
    tick();
    chk("qs_ack_gone", swap_ack, 0);
    chk("qs_front", front_sel, !f0);
  endtask

  initial begin
    int acks, clr, ready_bad;
    bit found;
    repeat (3) tick();
    chk("rst_front", front_sel, 0);
    chk("rst_wbuf", mem_wbuf, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_ready", draw_ready, 0);
    chk("rst_busy", busy, 1);
    rst_n = 1;
    for (int i = 0; i < FBW; i++) begin
      tick();
      chk("init_clr_we", mem_we, 1);
      chk("init_clr_addr", mem_waddr, i);
      chk("init_clr_wbuf", mem_wbuf, 1);
    end
    chk("init_ready", draw_ready, 1);
    chk("init_busy", busy, 0);
    draw_valid = 1; draw_addr = 5; draw_data = 12'hABC;
    tick();
    draw_valid = 0;
    chk("beat_we", mem_we, 1);
    chk("beat_addr", mem_waddr, 5);
    chk("beat_data", mem_wdata, 12'hABC);
    chk("beat_wbuf", mem_wbuf, 1);
    draw_valid = 1; draw_addr = 16;
    tick();
    draw_valid = 0;
    chk("oob_we", mem_we, 0);
    chk("oob_flag", wr_oob, 1);
    chk("oob_ready", draw_ready, 1);
    tick();
    chk("oob_pulse", wr_oob, 0);
    swap_req = 1;
    tick();
    acks = 0; clr = 0; ready_bad = 0;
    for (int k = 0; k < 140; k++) begin
      frame_start = k >= 100 && k < 104;
      tick();
      if (swap_ack) begin acks++; swap_req = 0; end
      if (k < 100 && draw_ready) ready_bad++;
      if (mem_we && !mem_wbuf) clr++;
    end
    chk("wait_ready_low", ready_bad, 0);
    chk("wait_acks", acks, 1);
    chk("wait_front", front_sel, 1);
    chk("wait_clear_words", clr, FBW);
    chk("wait_back_ready", draw_ready, 1);
    quick_swap();
    repeat (FBW + 2) tick();
    quick_swap();
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (mem_we && mem_waddr == 7) found = 1;
    end
    chk("clr7_seen", found, 1);
    rst_n = 0;
    tick();
    chk("abort_front", front_sel, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_wbuf", mem_wbuf, 1);
    chk("abort_busy", busy, 1);
    rst_n = 1;
    tick();
    chk("restart_we", mem_we, 1);
    chk("restart_addr", mem_waddr, 0);
    chk("restart_wbuf", mem_wbuf, 1);
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (swap_ack) swap_req = 0;
      else if (!swap_req) swap_req = $urandom_range(0, 30) == 0;
      else if ($urandom_range(0, 150) == 0) swap_req = 0;
      if ($urandom_range(0, 5) == 0) frame_start = !frame_start;
      draw_valid = 1'($urandom_range(0, 1));
      draw_addr = AB'($urandom_range(0, 20));
      draw_data = DB'($urandom);
      rst_n = $urandom_range(0, 399) != 0;
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
